// File: rtl/sap_alu_accumulator.sv
// SAP accumulator with add/subtract ALU and C/Z/V flags.
// Commands and results move over two independent valid/ready handshakes.
module sap_alu_accumulator #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic             v_q, v_d;

    logic             cmd_accept;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LDA;
            ld_q        <= '0;
            acc_q       <= RESET_VAL;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= (RESET_VAL == '0);
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ld_q        <= ld_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            z_q         <= z_d;
            v_q         <= v_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_accept) begin
                    state_d = (cmd_op == OP_OUT) ? S_HOLD : S_EXEC;
                end
            end
            S_EXEC: state_d = S_IDLE;
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs; ready is masked while reset is asserted
    always_comb begin
        cmd_ready  = (state_q == S_IDLE) && !rst;
        cmd_accept = cmd_valid && cmd_ready;
        out_valid  = out_valid_q;
        result     = result_q;
        acc        = acc_q;
        flag_c     = c_q;
        flag_z     = z_q;
        flag_v     = v_q;
    end

    // Subtraction is A + ~B + 1, so carry out means no borrow
    always_comb begin
        is_sub = (op_q == OP_SUB);
        b_op   = is_sub ? ~b_data : b_data;
        sum    = {1'b0, acc_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        res    = sum[WIDTH-1:0];
    end

    always_comb begin
        op_d        = op_q;
        ld_d        = ld_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        z_d         = z_q;
        v_d         = v_q;

        if (cmd_accept) begin
            op_d = cmd_op;
            ld_d = bus_in;
            if (cmd_op == OP_OUT) begin
                result_d    = acc_q;
                out_valid_d = 1'b1;
            end
        end

        if (state_q == S_EXEC) begin
            if (op_q == OP_LDA) begin
                acc_d = ld_q;
                z_d   = (ld_q == '0);
            end else if (op_q == OP_ADD || op_q == OP_SUB) begin
                acc_d = res;
                c_d   = sum[WIDTH];
                z_d   = (res == '0);
                v_d   = (acc_q[WIDTH-1] == b_op[WIDTH-1]) &&
                        (res[WIDTH-1] != acc_q[WIDTH-1]);
            end
        end

        if (state_q == S_HOLD && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_sap_alu_accumulator.sv
// Directed-vector bench for sap_alu_accumulator.
// Inputs change on falling edges; outputs are sampled on falling edges.
`timescale 1ns/1ps
module tb_sap_alu_accumulator;

    localparam logic [1:0] LDA = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] OUT = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] b_data = '0;
    logic [7:0] bus_in = '0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic       cmd_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic [7:0] acc;
    logic       flag_c, flag_z, flag_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sap_alu_accumulator #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .b_data(b_data), .bus_in(bus_in),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge right after the accept edge
    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("issue_timeout", 32'd0, 32'd1);
        cmd_op    = op;
        bus_in    = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic exec(input logic [1:0] op, input logic [7:0] data);
        issue(op, data);
        @(negedge clk);
    endtask

    task automatic flags(input string tag, input logic [7:0] a,
                         input logic c, input logic z, input logic v);
        chk({tag, "_acc"}, acc, a);
        chk({tag, "_c"}, flag_c, c);
        chk({tag, "_z"}, flag_z, z);
        chk({tag, "_v"}, flag_v, v);
    endtask

    initial begin
        // T1 reset
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        flags("rst", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rst_oval", out_valid, 1'b0);
        chk("rst_result", result, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", cmd_ready, 1'b1);

        // T2 5+3 then OUT
        b_data = 8'h03;
        exec(LDA, 8'h05);
        chk("t2_lda", acc, 8'h05);
        exec(ADD, 8'h00);
        flags("t2_add", 8'h08, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        issue(OUT, 8'h00);
        chk("t2_oval", out_valid, 1'b1);
        chk("t2_result", result, 8'h08);
        @(negedge clk);
        chk("t2_oval_clr", out_valid, 1'b0);
        chk("t2_ready", cmd_ready, 1'b1);
        out_ready = 1'b0;

        // T3 carry/zero, then signed overflow
        b_data = 8'h01;
        exec(LDA, 8'hFF);
        exec(ADD, 8'h00);
        flags("t3_wrap", 8'h00, 1'b1, 1'b1, 1'b0);
        exec(LDA, 8'h7F);
        exec(ADD, 8'h00);
        flags("t3_ovf", 8'h80, 1'b0, 1'b0, 1'b1);

        // T4 subtraction; LDA keeps C and V
        b_data = 8'h05;
        exec(LDA, 8'h03);
        flags("t4_lda", 8'h03, 1'b0, 1'b0, 1'b1);
        exec(SUB, 8'h00);
        flags("t4_borrow", 8'hFE, 1'b0, 1'b0, 1'b0);
        exec(LDA, 8'h05);
        exec(SUB, 8'h00);
        flags("t4_eq", 8'h00, 1'b1, 1'b1, 1'b0);
        b_data = 8'h01;
        exec(SUB, 8'h00);
        flags("t4_under", 8'hFF, 1'b0, 1'b0, 1'b0);
        exec(LDA, 8'h80);
        exec(SUB, 8'h00);
        flags("t4_sovf", 8'h7F, 1'b1, 1'b0, 1'b1);

        // T5 back-pressure on OUT with a pending ADD
        exec(LDA, 8'h42);
        out_ready = 1'b0;
        issue(OUT, 8'h00);
        cmd_op    = ADD;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t5_oval", out_valid, 1'b1);
            chk("t5_result", result, 8'h42);
            chk("t5_ready", cmd_ready, 1'b0);
            chk("t5_acc", acc, 8'h42);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_oval_clr", out_valid, 1'b0);
        chk("t5_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        chk("t5_in_exec", cmd_ready, 1'b0);
        @(negedge clk);
        flags("t5_add", 8'h43, 1'b0, 1'b0, 1'b0);
        chk("t5_result_kept", result, 8'h42);

        // T6 reset during EXEC and during HOLD
        issue(ADD, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("t6e_ready", cmd_ready, 1'b0);
        flags("t6e", 8'h00, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6e_idle", cmd_ready, 1'b1);
        chk("t6e_acc_hold", acc, 8'h00);
        exec(LDA, 8'h11);
        issue(OUT, 8'h00);
        chk("t6h_oval", out_valid, 1'b1);
        chk("t6h_result", result, 8'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6h_oval_clr", out_valid, 1'b0);
        chk("t6h_result_clr", result, 8'h00);
        chk("t6h_acc", acc, 8'h00);
        @(negedge clk);
        chk("t6h_idle", cmd_ready, 1'b1);
        chk("t6h_oval_stay", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
